// File: rtl/counter_param.sv
`default_nettype none
// ============================================================================
// Module   : counter_param
// Purpose  : Parametrised up/down iteration counter with load, clear,
//            terminal flag and registered done pulse. Optional saturation
//            mode (hold at terminal point, adds sat output) is enabled by
//            defining COUNTER_PARAM_SATURATE_EN.
// Revision : 1.0 - initial release
// ============================================================================
module counter_param #(
  parameter int unsigned       WIDTH    = 5,
  parameter logic [WIDTH-1:0]  TERMINAL = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic             sclr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dir,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             done
`ifdef COUNTER_PARAM_SATURATE_EN
  ,
  output logic             sat
`endif
);

  localparam logic [WIDTH-1:0] c_zero = '0;
  localparam logic [WIDTH-1:0] c_one  = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] r_q;
  logic             r_done;
  logic [WIDTH-1:0] w_step_q;
  logic [WIDTH-1:0] w_load_q;
  logic             w_tc;
  logic             w_step_hits_term;

  // Terminal point follows the current direction: TERMINAL going up, 0 going down.
  assign w_tc = dir ? (r_q == TERMINAL) : (r_q == c_zero);

  always_comb begin
    w_step_q = r_q;
    if (dir) begin
      w_step_q = (r_q == TERMINAL) ? c_zero : (r_q + c_one);
    end else begin
      w_step_q = (r_q == c_zero) ? TERMINAL : (r_q - c_one);
    end
  end

  assign w_step_hits_term = dir ? (w_step_q == TERMINAL) : (w_step_q == c_zero);
  assign w_load_q         = (load_val > TERMINAL) ? TERMINAL : load_val;

`ifdef COUNTER_PARAM_SATURATE_EN
  logic r_sat;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_q    <= c_zero;
      r_done <= 1'b0;
      r_sat  <= 1'b0;
    end else if (sclr) begin
      r_q    <= c_zero;
      r_done <= 1'b0;
      r_sat  <= 1'b0;
    end else if (load) begin
      r_q    <= w_load_q;
      r_done <= 1'b0;
      r_sat  <= 1'b0;
    end else if (en) begin
      if (w_tc) begin
        // Step blocked at the terminal point: hold and flag saturation.
        r_done <= 1'b0;
        r_sat  <= 1'b1;
      end else begin
        r_q    <= w_step_q;
        r_done <= w_step_hits_term;
        r_sat  <= 1'b0;
      end
    end else begin
      r_done <= 1'b0;
    end
  end

  assign sat = r_sat;
`else
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_q    <= c_zero;
      r_done <= 1'b0;
    end else if (sclr) begin
      r_q    <= c_zero;
      r_done <= 1'b0;
    end else if (load) begin
      r_q    <= w_load_q;
      r_done <= 1'b0;
    end else if (en) begin
      // A wrap lands on the opposite point, so it never raises done.
      r_q    <= w_step_q;
      r_done <= w_step_hits_term;
    end else begin
      r_done <= 1'b0;
    end
  end
`endif

  assign q    = r_q;
  assign tc   = w_tc;
  assign done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_counter_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_counter_param
// Purpose  : Self-checking bench for counter_param (TERMINAL=31 and 19).
// Revision : 1.0 - initial release
// ============================================================================
module tb_counter_param;

  logic       clk = 1'b0;
  logic       clr = 1'b0;
  logic       en = 1'b0, sclr = 1'b0, load = 1'b0, dir = 1'b1;
  logic [4:0] load_val = '0;
  logic [4:0] qa, qb;
  logic       tca, tcb, donea, doneb;
`ifdef COUNTER_PARAM_SATURATE_EN
  logic       sata, satb;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  counter_param #(.WIDTH(5), .TERMINAL(5'd31)) u_a (
    .clk(clk), .clr(clr), .en(en), .sclr(sclr), .load(load),
    .load_val(load_val), .dir(dir), .q(qa), .tc(tca), .done(donea)
`ifdef COUNTER_PARAM_SATURATE_EN
    , .sat(sata)
`endif
  );

  counter_param #(.WIDTH(5), .TERMINAL(5'd19)) u_b (
    .clk(clk), .clr(clr), .en(en), .sclr(sclr), .load(load),
    .load_val(load_val), .dir(dir), .q(qb), .tc(tcb), .done(doneb)
`ifdef COUNTER_PARAM_SATURATE_EN
    , .sat(satb)
`endif
  );

  typedef struct packed {
    logic       sel;   // 0 = TERMINAL 31 instance, 1 = TERMINAL 19 instance
    logic [4:0] q;
    logic       tc;
    logic       done;
    logic       sat;
    int         id;
  } exp_t;

  typedef struct packed {
    logic       sel;
    logic       sclr;
    logic       load;
    logic [4:0] lv;
    logic       en;
    logic       dir;
    logic [4:0] q;
    logic       tc;
    logic       done;
    logic       sat;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[$];

  task automatic compare(input exp_t e);
    logic [4:0] aq;
    logic       atc, adone, asat, bad;
    aq    = e.sel ? qb    : qa;
    atc   = e.sel ? tcb   : tca;
    adone = e.sel ? doneb : donea;
    asat  = 1'b0;
    bad   = (aq !== e.q) || (atc !== e.tc) || (adone !== e.done);
`ifdef COUNTER_PARAM_SATURATE_EN
    asat = e.sel ? satb : sata;
    bad  = bad || (asat !== e.sat);
`endif
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL chk%0d dut%0d: got q=%0d tc=%0d done=%0d sat=%0d, want q=%0d tc=%0d done=%0d sat=%0d",
               e.id, e.sel, aq, atc, adone, asat, e.q, e.tc, e.done, e.sat);
    end
  endtask

  task automatic step(input logic s, input logic sc, input logic ld, input logic [4:0] lv,
                      input logic en_i, input logic dir_i, input logic [4:0] eq,
                      input logic etc, input logic edone, input logic esat, input int id);
    sclr     = sc;
    load     = ld;
    load_val = lv;
    en       = en_i;
    dir      = dir_i;
    sb.push_back('{sel: s, q: eq, tc: etc, done: edone, sat: esat, id: id});
    @(posedge clk);
    #1;
    compare(sb.pop_front());
  endtask

  function automatic void add(input logic s, input logic sc, input logic ld, input logic [4:0] lv,
                              input logic en_i, input logic dir_i, input logic [4:0] eq,
                              input logic etc, input logic edone, input logic esat);
    vecs.push_back('{sel: s, sclr: sc, load: ld, lv: lv, en: en_i, dir: dir_i,
                     q: eq, tc: etc, done: edone, sat: esat});
  endfunction

  initial begin
    logic [4:0] eq;
    logic       etc, edone, esat;

    // TERMINAL=19, down direction, priority, clamp and hold cases
    add(1, 0, 1, 5'd3,  0, 0, 5'd3,  0, 0, 0);
    add(1, 0, 0, 5'd0,  1, 0, 5'd2,  0, 0, 0);
    add(1, 0, 0, 5'd0,  1, 0, 5'd1,  0, 0, 0);
    add(1, 0, 0, 5'd0,  1, 0, 5'd0,  1, 1, 0);
`ifdef COUNTER_PARAM_SATURATE_EN
    add(1, 0, 0, 5'd0,  1, 0, 5'd0,  1, 0, 1);
    add(1, 0, 0, 5'd0,  1, 0, 5'd0,  1, 0, 1);
`else
    add(1, 0, 0, 5'd0,  1, 0, 5'd19, 0, 0, 0);
    add(1, 0, 0, 5'd0,  1, 0, 5'd18, 0, 0, 0);
`endif
    add(1, 1, 1, 5'd10, 1, 0, 5'd0,  1, 0, 0);
    add(1, 0, 1, 5'd25, 0, 1, 5'd19, 1, 0, 0);
    add(1, 0, 1, 5'd7,  1, 1, 5'd7,  0, 0, 0);
    add(1, 0, 1, 5'd19, 1, 1, 5'd19, 1, 0, 0);
    add(1, 0, 0, 5'd0,  0, 1, 5'd19, 1, 0, 0);
    add(1, 0, 1, 5'd1,  0, 0, 5'd1,  0, 0, 0);
    add(1, 0, 0, 5'd0,  1, 0, 5'd0,  1, 1, 0);
    add(1, 0, 0, 5'd0,  0, 0, 5'd0,  1, 0, 0);

    // Reset state while clr is held low
    #12;
    compare('{sel: 0, q: 5'd0, tc: 1'b0, done: 1'b0, sat: 1'b0, id: 1});
    compare('{sel: 1, q: 5'd0, tc: 1'b0, done: 1'b0, sat: 1'b0, id: 2});
    #1 clr = 1'b1;

    for (int i = 1; i <= 9; i++)
      step(0, 0, 0, 5'd0, 1, 1, 5'(i), 0, 0, 0, 10 + i);

    // Asynchronous clear mid-cycle, 3 ns wide
    #2 clr = 1'b0;
    #1 compare('{sel: 0, q: 5'd0, tc: 1'b0, done: 1'b0, sat: 1'b0, id: 20});
    #2 clr = 1'b1;
    step(0, 0, 0, 5'd0, 1, 1, 5'd1, 0, 0, 0, 21);
    step(0, 1, 0, 5'd0, 1, 1, 5'd0, 0, 0, 0, 22);

    // Up count across the terminal value
    for (int i = 1; i <= 33; i++) begin
`ifdef COUNTER_PARAM_SATURATE_EN
      eq    = (i >= 31) ? 5'd31 : 5'(i);
      etc   = (i >= 31);
      esat  = (i >= 32);
`else
      eq    = 5'(i % 32);
      etc   = (i == 31);
      esat  = 1'b0;
`endif
      edone = (i == 31);
      step(0, 0, 0, 5'd0, 1, 1, eq, etc, edone, esat, 30 + i);
    end

    for (int i = 0; i < vecs.size(); i++)
      step(vecs[i].sel, vecs[i].sclr, vecs[i].load, vecs[i].lv, vecs[i].en, vecs[i].dir,
           vecs[i].q, vecs[i].tc, vecs[i].done, vecs[i].sat, 100 + i);

    // tc responds to dir with no clock edge (B holds q=0)
    dir = 1'b1;
    #1 compare('{sel: 1, q: 5'd0, tc: 1'b0, done: 1'b0, sat: 1'b0, id: 200});
    dir = 1'b0;
    #1 compare('{sel: 1, q: 5'd0, tc: 1'b1, done: 1'b0, sat: 1'b0, id: 201});

    // Direction flip mid-count
    step(0, 1, 0, 5'd0, 0, 1, 5'd0, 0, 0, 0, 210);
    for (int i = 1; i <= 5; i++)
      step(0, 0, 0, 5'd0, 1, 1, 5'(i), 0, 0, 0, 210 + i);
    step(0, 0, 0, 5'd0, 1, 0, 5'd4, 0, 0, 0, 216);
    step(0, 0, 0, 5'd0, 1, 1, 5'd5, 0, 0, 0, 217);

`ifdef COUNTER_PARAM_SATURATE_EN
    // Saturation at TERMINAL=31, release by reversing direction
    step(0, 0, 1, 5'd30, 0, 1, 5'd30, 0, 0, 0, 300);
    step(0, 0, 0, 5'd0,  1, 1, 5'd31, 1, 1, 0, 301);
    for (int i = 0; i < 4; i++)
      step(0, 0, 0, 5'd0, 1, 1, 5'd31, 1, 0, 1, 302 + i);
    step(0, 0, 0, 5'd0,  1, 0, 5'd30, 0, 0, 0, 306);
`else
    // Wrap at TERMINAL=19 in both directions
    step(1, 0, 1, 5'd19, 0, 1, 5'd19, 1, 0, 0, 300);
    step(1, 0, 0, 5'd0,  1, 1, 5'd0,  0, 0, 0, 301);
    step(1, 0, 1, 5'd0,  0, 0, 5'd0,  1, 0, 0, 302);
    step(1, 0, 0, 5'd0,  1, 0, 5'd19, 0, 0, 0, 303);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
